// File: rtl/solitaire_pkg.sv
// Shared peg-solitaire definitions: board geometry, move directions and the
// on-board test for the 7x7 English cross layout.
package solitaire_pkg;

   localparam int BOARD_N      = 7;
   localparam int BOARD_MID_LO = 2;
   localparam int BOARD_MID_HI = 4;

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_RIGHT = 2'd1,
      DIR_DOWN  = 2'd2,
      DIR_LEFT  = 2'd3
   } dir_t;

   // Signed 4-bit coordinates so that a target computed as source-2 can go negative.
   function automatic logic on_board(input logic signed [3:0] x,
                                     input logic signed [3:0] y);
      logic signed [3:0] lo;
      logic signed [3:0] hi;
      logic signed [3:0] lim;
      logic              x_in;
      logic              y_in;
      logic              x_mid;
      logic              y_mid;
      lo    = 4'(BOARD_MID_LO);
      hi    = 4'(BOARD_MID_HI);
      lim   = 4'(BOARD_N - 1);
      x_in  = !x[3] && (x <= lim);
      y_in  = !y[3] && (y <= lim);
      x_mid = (x >= lo) && (x <= hi);
      y_mid = (y >= lo) && (y <= hi);
      return x_in && y_in && (x_mid || y_mid);
   endfunction

endpackage

// File: rtl/solitaire_sync.sv
// Parameterised multi-flop synchroniser for asynchronous switch inputs.
module solitaire_sync #(
   parameter int STAGES = 2,
   parameter int W      = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] sync_p [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) sync_p[i] <= '0;
      end else begin
         sync_p[0] <= d;
         for (int i = 1; i < STAGES; i++) sync_p[i] <= sync_p[i-1];
      end
   end

   assign q = sync_p[STAGES-1];

endmodule

// File: rtl/solitaire_move_capture.sv
// Switch front end for the peg-solitaire engine: synchronise, debounce, screen the
// move geometry, then offer legal moves on valid/ready or pulse a reject.
module solitaire_move_capture
   import solitaire_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] ui_in,
   output logic       move_valid,
   input  logic       move_ready,
   output logic [2:0] move_x,
   output logic [2:0] move_y,
   output logic [1:0] move_dir,
   output logic       move_reject,
   output logic       busy
);

   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_OFFER  = 2'd3
   } state_t;

   state_t           state;
   logic [7:0]       s;
   logic [7:0]       cand;
   logic [7:0]       stable_ref;
   logic [CNT_W-1:0] cnt;

   solitaire_sync #(
      .STAGES (SYNC_STAGES),
      .W      (8)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (ui_in),
      .q     (s)
   );

   function automatic logic legal(input logic [7:0] c);
      logic signed [3:0] sx;
      logic signed [3:0] sy;
      logic signed [3:0] tx;
      logic signed [3:0] ty;
      sx = signed'({1'b0, c[2:0]});
      sy = signed'({1'b0, c[5:3]});
      tx = sx;
      ty = sy;
      case (dir_t'(c[7:6]))
         DIR_UP:    ty = sy - 4'sd2;
         DIR_RIGHT: tx = sx + 4'sd2;
         DIR_DOWN:  ty = sy + 4'sd2;
         DIR_LEFT:  tx = sx - 4'sd2;
         default:   tx = sx;
      endcase
      return on_board(sx, sy) && on_board(tx, ty);
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cand        <= '0;
         stable_ref  <= '0;
         cnt         <= '0;
         move_valid  <= 1'b0;
         move_reject <= 1'b0;
         move_x      <= '0;
         move_y      <= '0;
         move_dir    <= '0;
         busy        <= 1'b0;
      end else begin
         move_reject <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (s != stable_ref) begin
                  state <= ST_SETTLE;
                  cand  <= s;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            ST_SETTLE: begin
               // Any change restarts the count, including a return to stable_ref.
               if (s != cand) begin
                  cand <= s;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  state <= ST_CHECK;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_CHECK: begin
               if (legal(cand)) begin
                  state      <= ST_OFFER;
                  move_valid <= 1'b1;
                  move_x     <= cand[2:0];
                  move_y     <= cand[5:3];
                  move_dir   <= cand[7:6];
               end else begin
                  move_reject <= 1'b1;
                  stable_ref  <= cand;
                  state       <= ST_IDLE;
                  busy        <= 1'b0;
               end
            end
            ST_OFFER: begin
               if (move_ready) begin
                  move_valid <= 1'b0;
                  stable_ref <= cand;
                  state      <= ST_IDLE;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_solitaire_move_capture.sv
// Directed bench for solitaire_move_capture with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_solitaire_move_capture;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] ui_in = 8'h00;
   logic       move_ready = 1'b0;
   logic       move_valid;
   logic [2:0] move_x;
   logic [2:0] move_y;
   logic [1:0] move_dir;
   logic       move_reject;
   logic       busy;

   int n_cmp = 0;
   int n_err = 0;

   solitaire_move_capture #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .ui_in       (ui_in),
      .move_valid  (move_valid),
      .move_ready  (move_ready),
      .move_x      (move_x),
      .move_y      (move_y),
      .move_dir    (move_dir),
      .move_reject (move_reject),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_valid"},  32'(move_valid),  32'd0);
      check({tag, "_reject"}, 32'(move_reject), 32'd0);
   endtask

   // Apply a step and check the 7-edge latency; optionally complete the handshake.
   task automatic expect_move(input logic [7:0] val, input bit is_legal,
                              input logic [2:0] ex, input logic [2:0] ey,
                              input logic [1:0] ed, input bit finish);
      ui_in = val;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check_quiet("pre");
      end
      tick();
      check("edge7_valid",  32'(move_valid),  32'(is_legal));
      check("edge7_reject", 32'(move_reject), 32'(!is_legal));
      check("edge7_busy",   32'(busy),        32'(is_legal));
      if (is_legal) begin
         check("payload_x",   32'(move_x),   32'(ex));
         check("payload_y",   32'(move_y),   32'(ey));
         check("payload_dir", 32'(move_dir), 32'(ed));
      end
      if (finish) begin
         tick();
         check_quiet("post");
         check("post_busy", 32'(busy), 32'd0);
         for (int i = 0; i < 4; i++) begin
            tick();
            check_quiet("after");
         end
      end
   endtask

   initial begin
      // Test 1: reset state and quiet idle
      #2;
      check("rst_valid",  32'(move_valid),  32'd0);
      check("rst_reject", 32'(move_reject), 32'd0);
      check("rst_busy",   32'(busy),        32'd0);
      check("rst_x",      32'(move_x),      32'd0);
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 50; i++) begin
         tick();
         check_quiet("idle");
         check("idle_busy", 32'(busy), 32'd0);
      end

      // Test 2: legal move x=3 y=1 down
      move_ready = 1'b1;
      expect_move(8'h8B, 1'b1, 3'd3, 3'd1, 2'd2, 1'b1);

      // Test 3: corner source is off-board
      expect_move(8'h40, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1);

      // Test 4: target x=7 off-board, then target y=1 on-board
      expect_move(8'h5D, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1);
      expect_move(8'h1A, 1'b1, 3'd2, 3'd3, 2'd0, 1'b1);

      // Test 5: bouncing input never settles; the final hold gives one offer
      for (int k = 0; k < 10; k++) begin
         ui_in = (k % 2 == 0) ? 8'h8B : 8'h00;
         tick();
         check_quiet("bounce");
         tick();
         check_quiet("bounce");
      end
      expect_move(8'h8B, 1'b1, 3'd3, 3'd1, 2'd2, 1'b1);

      // Test 6: stall with ready low while ui_in moves
      move_ready = 1'b0;
      expect_move(8'h1A, 1'b1, 3'd2, 3'd3, 2'd0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         ui_in = (i % 2 == 1) ? 8'h40 : 8'h5D;
         tick();
         check("hold_valid",  32'(move_valid),  32'd1);
         check("hold_reject", 32'(move_reject), 32'd0);
         check("hold_busy",   32'(busy),        32'd1);
         check("hold_x",      32'(move_x),      32'd2);
         check("hold_y",      32'(move_y),      32'd3);
         check("hold_dir",    32'(move_dir),    32'd0);
      end
      ui_in = 8'h1A;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold2_valid", 32'(move_valid), 32'd1);
      end
      move_ready = 1'b1;
      tick();
      check("accept_valid", 32'(move_valid), 32'd0);
      check("accept_busy",  32'(busy),       32'd0);
      for (int i = 0; i < 10; i++) begin
         tick();
         check_quiet("same_setting");
         check("same_busy", 32'(busy), 32'd0);
      end

      // Reset in the middle of an offer
      move_ready = 1'b0;
      expect_move(8'h8B, 1'b1, 3'd3, 3'd1, 2'd2, 1'b0);
      tick();
      tick();
      check("mid_valid", 32'(move_valid), 32'd1);
      ui_in = 8'h00;
      rst_n = 1'b0;
      #1;
      check("arst_valid",  32'(move_valid),  32'd0);
      check("arst_reject", 32'(move_reject), 32'd0);
      check("arst_busy",   32'(busy),        32'd0);
      check("arst_x",      32'(move_x),      32'd0);
      check("arst_y",      32'(move_y),      32'd0);
      check("arst_dir",    32'(move_dir),    32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 15; i++) begin
         tick();
         check_quiet("post_rst");
         check("post_rst_busy", 32'(busy), 32'd0);
      end
      move_ready = 1'b1;
      expect_move(8'h8B, 1'b1, 3'd3, 3'd1, 2'd2, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
